// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv arbiter: FSM state encoding, op codes
// and the requester count / port index type.
package multdiv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   localparam int NUM_REQ = 2;

   typedef logic [$clog2(NUM_REQ)-1:0] port_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick. On a tie the port that did not win last time
// is chosen; a lone valid port always wins.
module rr_arbiter2
   import multdiv_pkg::*;
(
   input  logic  valid0,
   input  logic  valid1,
   input  port_t last_grant,
   output port_t grant,
   output logic  grant_valid
);

   // Winner selection: alternate on ties, otherwise take the only requester
   always_comb begin
      grant = port_t'(0);
      if (valid0 && valid1) begin
         grant = (last_grant == port_t'(0)) ? port_t'(1) : port_t'(0);
      end else if (valid1) begin
         grant = port_t'(1);
      end
   end

   assign grant_valid = valid0 | valid1;

endmodule

// File: rtl/multdiv_arbiter.sv
// Shares one multdiv unit between two requesters. Operands are captured on
// acceptance and held for the whole operation because the divider path is
// combinational on them. One operation in flight at a time.
// Optional watchdog: define MULTDIV_ARB_TIMEOUT_EN to abort an operation
// after TIMEOUT_CYCLES waiting cycles with result 0 and exception 1.
module multdiv_arbiter
   import multdiv_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 40,
   parameter int CNT_W          = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic        req0_op,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic        req1_op,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        req1_ready,
   output logic        resp0_valid,
   output logic        resp1_valid,
   output logic [31:0] resp_result,
   output logic        resp_exception,
   output logic [31:0] md_operandA,
   output logic [31:0] md_operandB,
   output logic        md_ctrl_MULT,
   output logic        md_ctrl_DIV,
   input  logic [31:0] md_result,
   input  logic        md_exception,
   input  logic        md_resultRDY
);

   state_t      state;
   port_t       last_grant;
   port_t       owner;
   port_t       grant;
   logic        grant_valid;
   logic        op;
   logic        timed_out;
   logic        sel_op;
   logic [31:0] sel_a;
   logic [31:0] sel_b;

   if (2 ** CNT_W <= TIMEOUT_CYCLES) begin : g_cnt_w_too_small
      $error("multdiv_arbiter: CNT_W must satisfy 2**CNT_W > TIMEOUT_CYCLES");
   end

   rr_arbiter2 u_rr (
      .valid0      (req0_valid),
      .valid1      (req1_valid),
      .last_grant  (last_grant),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   // Ready is offered only to the winner and only while idle; never during reset
   assign req0_ready = !reset && (state == IDLE) && grant_valid &&
                       (grant == port_t'(0)) && req0_valid;
   assign req1_ready = !reset && (state == IDLE) && grant_valid &&
                       (grant == port_t'(1)) && req1_valid;

   assign sel_op = (grant == port_t'(0)) ? req0_op : req1_op;
   assign sel_a  = (grant == port_t'(0)) ? req0_a  : req1_a;
   assign sel_b  = (grant == port_t'(0)) ? req0_b  : req1_b;

   // Start pulses are a pure decode of registered state and op: ISSUE lasts one cycle
   assign md_ctrl_MULT = (state == ISSUE) && (op == OP_MULT);
   assign md_ctrl_DIV  = (state == ISSUE) && (op == OP_DIV);

`ifdef MULTDIV_ARB_TIMEOUT_EN
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] wd_cnt;

   // Watchdog: cleared while issuing, advances once per waiting cycle
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wd_cnt <= '0;
      end else if (state == ISSUE) begin
         wd_cnt <= '0;
      end else if (state == WAIT) begin
         wd_cnt <= wd_cnt + CNT_W'(1);
      end
   end

   assign timed_out = (state == WAIT) && (wd_cnt == WD_LAST) && !md_resultRDY;
`else
   assign timed_out = 1'b0;
`endif

   // Control FSM: accept, issue, wait for the unit, return the result to the owner
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         last_grant     <= port_t'(1);
         owner          <= port_t'(0);
         op             <= OP_MULT;
         md_operandA    <= '0;
         md_operandB    <= '0;
         resp_result    <= '0;
         resp_exception <= 1'b0;
         resp0_valid    <= 1'b0;
         resp1_valid    <= 1'b0;
      end else begin
         resp0_valid <= 1'b0;
         resp1_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  owner       <= grant;
                  last_grant  <= grant;
                  op          <= sel_op;
                  md_operandA <= sel_a;
                  md_operandB <= sel_b;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               // resultRDY may still be high from the previous operation here
               state <= WAIT;
            end
            WAIT: begin
               if (md_resultRDY) begin
                  resp_result    <= md_result;
                  resp_exception <= md_exception;
                  resp0_valid    <= (owner == port_t'(0));
                  resp1_valid    <= (owner == port_t'(1));
                  state          <= RESP;
               end else if (timed_out) begin
                  resp_result    <= '0;
                  resp_exception <= 1'b1;
                  resp0_valid    <= (owner == port_t'(0));
                  resp1_valid    <= (owner == port_t'(1));
                  state          <= RESP;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/multdiv_arbiter.md
Name: multdiv_arbiter

Overview:
Shares one multdiv unit between two requesters, e.g. the processor execute stage (port 0) and a second master such as a SHA helper or debug path (port 1).
- Arbitrates round-robin between the two requesters.
- Registers and holds the operands for the whole operation, because the divider path is combinational on its operands.
- Generates a one-cycle ctrl_MULT or ctrl_DIV pulse and waits for data_resultRDY.
- Returns the registered result to the requester that owns the operation.

Parameters:
TIMEOUT_CYCLES, 40, number of WAIT cycles before an operation is aborted (used only with MULTDIV_ARB_TIMEOUT_EN).
CNT_W, 6, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clock  in  1  single clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-high reset.
req0_valid  in  1  requester 0 has an operation.
req0_op  in  1  0 = multiply, 1 = divide.
req0_a  in  32  operand A (dividend or multiplicand).
req0_b  in  32  operand B.
req0_ready  out  1  request 0 accepted this cycle.
req1_valid, req1_op, req1_a, req1_b, req1_ready  same as port 0, for requester 1.
resp0_valid  out  1  one-cycle pulse: response for requester 0.
resp1_valid  out  1  one-cycle pulse: response for requester 1.
resp_result  out  32  result; valid while either resp*_valid is high.
resp_exception  out  1  exception flag; valid while either resp*_valid is high.
md_operandA  out  32  operand A to multdiv, held for the whole operation.
md_operandB  out  32  operand B to multdiv, held for the whole operation.
md_ctrl_MULT  out  1  multiply start pulse.
md_ctrl_DIV  out  1  divide start pulse.
md_result  in  32  multdiv data_result.
md_exception  in  1  multdiv data_exception.
md_resultRDY  in  1  multdiv data_resultRDY.

Behaviour:
Reset values (asynchronous):
- State = IDLE; last_grant = 1, so port 0 wins the first tie.
- All ready, valid and ctrl outputs = 0.
- md_operandA, md_operandB, resp_result, resp_exception = 0; owner = 0; op = 0.

State machine:
- IDLE:
  - Winner = the only valid port, or, when both are valid, the port not equal to last_grant.
  - reqN_ready is combinational: it is 1 only in IDLE, only for the winner, and only when reqN_valid = 1. The handshake completes in that cycle.
  - On acceptance: register a, b, op and owner; last_grant <= owner; go to ISSUE.
  - The non-winner's ready stays 0, and it must hold its request stable.
- ISSUE (exactly 1 cycle):
  - md_ctrl_MULT = (op == 0); md_ctrl_DIV = (op == 1). Never both.
  - md_resultRDY is ignored in this cycle, since it may be stale from the previous operation.
  - Go to WAIT.
- WAIT:
  - On md_resultRDY = 1: capture md_result into resp_result and md_exception into resp_exception; go to RESP.
- RESP (exactly 1 cycle):
  - resp<owner>_valid = 1; the other resp*_valid stays 0.
  - Go to IDLE. A new request can be accepted in the next cycle.

Fixed rules:
- md_operandA/B change only on acceptance and are otherwise held.
- The ctrl pulses are high only in ISSUE.
- Latency, from accept edge to resp_valid: 2 + (number of WAIT cycles). With a 32-cycle unit this is about 35 cycles.
- No queueing: at most one operation is in flight.
- resp_result and resp_exception are held after RESP until the next capture.
- Signed semantics are entirely the multdiv unit's. The arbiter passes all 32 bits unmodified.

Boundary conditions:
- Reset asserted in ISSUE, WAIT or RESP: the operation is abandoned, no response is issued, and the state returns to IDLE immediately. The multdiv unit's internal state is ignored; the next ISSUE pulse restarts it.
- A request deasserted before acceptance: simply dropped. The arbiter keeps no memory of it.
- Both ports valid continuously: grants alternate 0, 1, 0, 1, ...

Optional Feature:
MULTDIV_ARB_TIMEOUT_EN
- Defined:
  - A watchdog counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with md_resultRDY still 0: capture resp_result = 0 and resp_exception = 1, then go to RESP as normal.
  - The next ISSUE pulse restarts the unit.
- Undefined: no counter is built, TIMEOUT_CYCLES is unused, and WAIT persists until md_resultRDY.

Decomposition:
- Package multdiv_pkg holds:
  - the state encoding (IDLE, ISSUE, WAIT, RESP, 2 bits);
  - the op encoding constants OP_MULT = 0 and OP_DIV = 1;
  - the port count constant NUM_REQ = 2.
- One sub-module, rr_arbiter2: combinational two-way round-robin pick from (valid0, valid1, last_grant), producing a grant index and a grant-valid output. The FSM, operand registers and watchdog stay in the top.

Test Plan:
- Mult: port 0 requests a = 6, b = 7, op = 0, with a multdiv model → one md_ctrl_MULT pulse one cycle after accept; resp0_valid pulse with result = 42, exception = 0; resp1_valid stays 0.
- Div: port 1 requests a = -20 (32'hFFFFFFEC), b = 3, op = 1 → md_ctrl_DIV pulse; resp1_valid with result = -6 (32'hFFFFFFFA); md_operandA stays 32'hFFFFFFEC through WAIT.
- Div by zero: port 0 sends a = 5, b = 0, op = 1 → resp0_valid with exception = 1.
- Tie and fairness: both ports valid from reset with back-to-back requests → grant order 0, 1, 0, 1; each response reaches the correct port; no overlapping operations.
- Reset mid-op: assert reset in the 10th WAIT cycle → all outputs return to reset values immediately and no response pulse occurs. A following port-1 request of 3*3 returns 9.
- Timeout (macro defined, TIMEOUT_CYCLES = 40): hold md_resultRDY at 0 → resp0_valid exactly 40 WAIT cycles later with result = 0 and exception = 1. Macro undefined: still waiting at 100 cycles.
